// File: rtl/fifo_rr_ctrl.sv
// Round-robin write arbiter in front of a shared sync_fifo, with a 2-entry
// skid buffer on the read side that hides the FIFO's one-cycle read latency.
module fifo_rr_ctrl #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  localparam int PW         = $clog2(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          fifo_wr_en_o,
  output logic [DATA_WIDTH-1:0]         fifo_din_o,
  input  logic                          fifo_full_i,
  output logic                          fifo_rd_en_o,
  input  logic [DATA_WIDTH-1:0]         fifo_dout_i,
  input  logic                          fifo_empty_i,
  output logic                          out_valid_o,
  output logic [DATA_WIDTH-1:0]         out_data_o,
  input  logic                          out_ready_i,
  output logic [PW-1:0]                 last_grant_o
);

  logic [PW-1:0] rr_ptr, gnt_idx, srch, ptr_nxt;
  logic          gnt_any, gnt;

  // Walk offsets high to low so the closest valid requester to rr_ptr wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    srch    = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      srch = PW'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_valid_i[srch]) begin
        gnt_any = 1'b1;
        gnt_idx = srch;
      end
    end
  end

  assign gnt          = gnt_any & ~fifo_full_i & ~rst_i;
  assign ptr_nxt      = (gnt_idx == PW'(NUM_REQ-1)) ? '0 : gnt_idx + PW'(1);
  assign req_ready_o  = gnt ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign fifo_wr_en_o = gnt;
  assign fifo_din_o   = gnt ? req_data_i[gnt_idx*DATA_WIDTH +: DATA_WIDTH] : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr       <= '0;
      last_grant_o <= '0;
    end else if (gnt) begin
      rr_ptr       <= ptr_nxt;
      last_grant_o <= gnt_idx;
    end
  end

  // Read side: occ words held, inflight read whose data lands next cycle.
  logic [1:0]            occ, occ_nxt;
  logic                  inflight, pop, slot;
  logic [2:0]            demand;
  logic [DATA_WIDTH-1:0] buf_q [2];

  assign pop          = out_valid_o & out_ready_i;
  assign demand       = 3'(occ) + 3'(inflight) - 3'(pop);
  assign fifo_rd_en_o = ~rst_i & ~fifo_empty_i & (demand < 3'd2);
  assign occ_nxt      = occ + 2'(inflight) - 2'(pop);
  // Tail position after any pop this cycle; space was reserved at issue time.
  assign slot         = (occ - 2'(pop)) != 2'd0;
  assign out_data_o   = buf_q[0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ         <= '0;
      inflight    <= 1'b0;
      out_valid_o <= 1'b0;
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
    end else begin
      inflight    <= fifo_rd_en_o;
      occ         <= occ_nxt;
      out_valid_o <= occ_nxt != 2'd0;
      if (pop)      buf_q[0]    <= buf_q[1];
      if (inflight) buf_q[slot] <= fifo_dout_i;
    end
  end

endmodule

// File: tb/tb_fifo_rr_ctrl.sv
// Bench for fifo_rr_ctrl with a behavioural depth-8 sync_fifo and an
// output scoreboard fed by the directed stimulus.
module tb_fifo_rr_ctrl;

  logic        clk, rst;
  logic [3:0]  req_valid, req_ready;
  logic [31:0] req_data;
  logic        fifo_wr_en, fifo_full, fifo_rd_en, fifo_empty;
  logic [7:0]  fifo_din, fifo_dout, out_data;
  logic        out_valid, out_ready;
  logic [1:0]  last_grant;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  mon_exp;

  fifo_rr_ctrl #(.NUM_REQ(4), .DATA_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(req_ready),
    .fifo_wr_en_o(fifo_wr_en), .fifo_din_o(fifo_din), .fifo_full_i(fifo_full),
    .fifo_rd_en_o(fifo_rd_en), .fifo_dout_i(fifo_dout), .fifo_empty_i(fifo_empty),
    .out_valid_o(out_valid), .out_data_o(out_data), .out_ready_i(out_ready),
    .last_grant_o(last_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural sync_fifo: registered flags, dout one cycle after rd_en.
  logic [7:0] fmem [8];
  logic [3:0] fcnt;
  logic [2:0] fwp, frp;
  assign fifo_empty = (fcnt == 4'd0);
  assign fifo_full  = (fcnt == 4'd8);

  always @(posedge clk) begin
    if (rst) begin
      fcnt <= 4'd0;
      fwp  <= 3'd0;
      frp  <= 3'd0;
    end else begin
      if (fifo_wr_en && !fifo_full) begin
        fmem[fwp] <= fifo_din;
        fwp       <= fwp + 3'd1;
      end
      if (fifo_rd_en && !fifo_empty) begin
        fifo_dout <= fmem[frp];
        frp       <= frp + 3'd1;
      end
      fcnt <= fcnt + 4'(fifo_wr_en && !fifo_full) - 4'(fifo_rd_en && !fifo_empty);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_drain_timeout: %0d words outstanding, expected 0", name, exp_q.size());
    end
    repeat (3) tick();
  endtask

  // Scoreboard monitor: every accepted output word must match the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL out_unexpected: got %02h, expected no word", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("out_data", 32'(out_data), 32'(mon_exp));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int k, n, rd_cnt;
    rst       = 1'b1;
    out_ready = 1'b0;
    req_valid = 4'hF;
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'h10 + 8'(i);

    // Reset held with every requester valid
    for (int c = 0; c < 5; c++) begin
      tick();
      @(negedge clk);
      check("rst_ready", 32'(req_ready), 0);
      check("rst_wr_en", 32'(fifo_wr_en), 0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_last_grant", 32'(last_grant), 0);
    end

    // Round-robin stream, all valid, full throughput after 3-cycle fill
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      req_valid = (c < 8) ? 4'hF : 4'h0;
      @(negedge clk);
      if (c < 8) begin
        check("rr_grant", 32'(req_ready), 32'(1 << (c % 4)));
        exp_q.push_back(8'h10 + 8'(c % 4));
      end
      if (c >= 3 && c <= 10) check("rr_stream_valid", 32'(out_valid), 1);
      if (c == 11) check("rr_idle", 32'(out_valid), 0);
      tick();
    end
    wait_drain("rr");

    // Single word latency from requester 2
    req_valid = 4'b0100;
    req_data[23:16] = 8'hA5;
    @(negedge clk);
    check("lat_grant", 32'(req_ready), 4);
    check("lat_din", 32'(fifo_din), 32'h A5);
    exp_q.push_back(8'hA5);
    tick();
    req_valid = 4'b0000;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check("lat_last_grant", 32'(last_grant), 2);
      check("lat_out_valid", 32'(out_valid), (c == 3) ? 1 : 0);
      tick();
    end
    wait_drain("lat");

    // Backpressure: 10 words into depth-8 FIFO with the consumer stalled
    out_ready = 1'b0;
    rd_cnt    = 0;
    k         = 0;
    n         = 0;
    req_valid = 4'b0001;
    while (k < 10 && n < 40) begin
      req_data[7:0] = 8'h20 + 8'(k);
      @(negedge clk);
      if (fifo_rd_en) rd_cnt++;
      if (req_ready[0]) begin
        exp_q.push_back(8'h20 + 8'(k));
        k++;
      end
      n++;
      tick();
    end
    check("bp_words_accepted", 32'(k), 10);
    req_data[7:0] = 8'hEE;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (fifo_rd_en) rd_cnt++;
      check("bp_full_ready", 32'(req_ready), 0);
      check("bp_full_wr_en", 32'(fifo_wr_en), 0);
      check("bp_hold_valid", 32'(out_valid), 1);
      check("bp_hold_data", 32'(out_data), 32'h20);
      tick();
    end
    req_valid = 4'b0000;
    check("bp_rd_pulses", 32'(rd_cnt), 2);
    out_ready = 1'b1;
    wait_drain("bp");

    // Skip and fairness: move rr_ptr to 2, then only requesters 1 and 3
    req_valid = 4'b0010;
    req_data[15:8] = 8'h41;
    @(negedge clk);
    check("skip_setup_grant", 32'(req_ready), 2);
    exp_q.push_back(8'h41);
    tick();
    req_valid = 4'b1010;
    req_data[15:8]  = 8'h31;
    req_data[31:24] = 8'h33;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("skip_grant", 32'(req_ready), (c == 1) ? 2 : 8);
      check("skip_last_grant", 32'(last_grant), (c == 1) ? 3 : 1);
      exp_q.push_back((c == 1) ? 8'h31 : 8'h33);
      tick();
    end
    req_valid = 4'b0000;
    @(negedge clk);
    check("skip_last_grant_end", 32'(last_grant), 3);
    tick();
    wait_drain("skip");

    // Mid-operation reset while words are buffered and a read is in flight
    out_ready = 1'b0;
    req_valid = 4'b0010;
    for (int c = 0; c < 4; c++) begin
      req_data[15:8] = 8'h60 + 8'(c);
      if (c == 3) rst = 1'b1;
      @(negedge clk);
      if (c < 3) check("mr_grant", 32'(req_ready), 2);
      else begin
        check("mr_pre_valid", 32'(out_valid), 1);
        check("mr_rst_ready", 32'(req_ready), 0);
        check("mr_rst_wr_en", 32'(fifo_wr_en), 0);
        check("mr_rst_rd_en", 32'(fifo_rd_en), 0);
      end
      tick();
    end
    rst       = 1'b0;
    req_valid = 4'b0000;
    out_ready = 1'b1;
    @(negedge clk);
    check("mr_valid_cleared", 32'(out_valid), 0);
    check("mr_last_grant", 32'(last_grant), 0);
    tick();
    // rr_ptr must restart at 0: requester 0 beats requester 3
    req_valid = 4'b1001;
    req_data[7:0]   = 8'h5A;
    req_data[31:24] = 8'h77;
    @(negedge clk);
    check("mr_post_grant", 32'(req_ready), 1);
    exp_q.push_back(8'h5A);
    tick();
    req_valid = 4'b0000;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check("mr_post_latency", 32'(out_valid), (c == 3) ? 1 : 0);
      tick();
    end
    wait_drain("mr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
